ysyx_22041071_exu: RTL and testbench

YSYX_22041071_EXU -- requirements
Module: ysyx_22041071_exu

---
 rtl/ysyx_22041071_exu.sv | 248 ++++++++++++++++++++++++
 tb/tb_ysyx_22041071_exu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_exu.sv
// ysyx_22041071_exu: execute stage with single-cycle ALU, branch resolution and
// iterative 64-cycle multiply/divide behind a valid/ready pipeline register.
module ysyx_22041071_exu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid4,
    output logic            ready4,
    input  logic [XLEN-1:0] PC4,
    input  logic [31:0]     Ins3,
    input  logic [11:0]     BImm2,
    input  logic            Brch2,
    input  logic [4:0]      ALU_ctrl2,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            MEM_W_en2,
    input  logic            WB_sel2,
    input  logic            reg_w_en2,
    input  logic [4:0]      rdest1,
    input  logic [XLEN-1:0] rt_data1,
    output logic            valid5,
    input  logic            ready5,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdest1_,
    output logic            reg_w_en3_,
    output logic [XLEN-1:0] PC5,
    output logic [31:0]     Ins4,
    output logic            MEM_W_en3,
    output logic            WB_sel3,
    output logic [XLEN-1:0] rt_data2,
    output logic            Brch_taken,
    output logic [XLEN-1:0] BPC
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [63:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic [4:0]   op_q, op_d;
    logic         qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic         valid_q, valid_d, rwe_q, rwe_d, brt_q, brt_d, memw_q, memw_d, wbs_q, wbs_d;
    logic [63:0]  res_q, res_d, pc_q, pc_d, rt_q, rt_d, bpc_q, bpc_d;
    logic [31:0]  ins_q, ins_d;
    logic [4:0]   rd_q, rd_d;

    logic         in_fire, out_fire, multi, is_mul, sgn, a_neg, b_neg, slt, cond;
    logic [5:0]   sh;
    logic [4:0]   shw;
    logic [63:0]  sra, a_mag, b_mag, alu, quot, rem, mres;
    logic [31:0]  addw, subw, sllw, srlw, sraw;
    logic [64:0]  msum, dt, ddiff;
    logic [127:0] prod;

    assign in_fire  = valid4 & ready4;
    assign out_fire = valid_q & ready5;
    assign ready4   = reset & (state_q == IDLE) & (~valid_q | ready5);

    assign sh   = src_b[5:0];
    assign shw  = src_b[4:0];
    assign sra  = $signed(src_a) >>> sh;
    assign addw = src_a[31:0] + src_b[31:0];
    assign subw = src_a[31:0] - src_b[31:0];
    assign sllw = src_a[31:0] << shw;
    assign srlw = src_a[31:0] >> shw;
    assign sraw = $signed(src_a[31:0]) >>> shw;
    assign slt  = $signed(src_a) < $signed(src_b);

    always_comb begin
        alu = 64'd0;
        case (ALU_ctrl2)
            5'd0:  alu = src_a + src_b;
            5'd1:  alu = src_a - src_b;
            5'd2:  alu = src_a & src_b;
            5'd3:  alu = src_a | src_b;
            5'd4:  alu = src_a ^ src_b;
            5'd5:  alu = src_a << sh;
            5'd6:  alu = src_a >> sh;
            5'd7:  alu = sra;
            5'd8:  alu = {63'd0, slt};
            5'd9:  alu = {63'd0, src_a < src_b};
            5'd10: alu = {{32{addw[31]}}, addw};
            5'd11: alu = {{32{subw[31]}}, subw};
            5'd12: alu = {{32{sllw[31]}}, sllw};
            5'd13: alu = {{32{srlw[31]}}, srlw};
            5'd14: alu = {{32{sraw[31]}}, sraw};
            default: alu = 64'd0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (Ins3[14:12])
            3'b000: cond = src_a == src_b;
            3'b001: cond = src_a != src_b;
            3'b100: cond = slt;
            3'b101: cond = ~slt;
            3'b110: cond = src_a < src_b;
            3'b111: cond = src_a >= src_b;
            default: cond = 1'b0;
        endcase
    end

    // Iterative units work on magnitudes; signs are reapplied once in DONE.
    assign multi  = (ALU_ctrl2 >= 5'd16) && (ALU_ctrl2 <= 5'd21);
    assign is_mul = (ALU_ctrl2 == 5'd16) || (ALU_ctrl2 == 5'd17);
    assign sgn    = is_mul || (ALU_ctrl2 == 5'd18) || (ALU_ctrl2 == 5'd20);
    assign a_neg  = sgn & src_a[63];
    assign b_neg  = sgn & src_b[63];
    assign a_mag  = a_neg ? -src_a : src_a;
    assign b_mag  = b_neg ? -src_b : src_b;

    assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 65'd0);
    assign dt    = {hi_q, lo_q[63]};
    assign ddiff = dt - {1'b0, m_q};
    assign prod  = qneg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quot  = dz_q ? '1 : (qneg_q ? -lo_q : lo_q);
    assign rem   = rneg_q ? -hi_q : hi_q;
    assign mres  = op_q == 5'd16 ? prod[63:0] :
                   op_q == 5'd17 ? prod[127:64] :
                   (op_q == 5'd18 || op_q == 5'd19) ? quot : rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        valid_d = out_fire ? 1'b0 : valid_q;
        res_d   = res_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        memw_d  = memw_q;
        wbs_d   = wbs_q;
        rwe_d   = rwe_q;
        rd_d    = rd_q;
        rt_d    = rt_q;
        bpc_d   = bpc_q;
        brt_d   = brt_q;
        if (in_fire) begin
            pc_d   = PC4;
            ins_d  = Ins3;
            memw_d = MEM_W_en2;
            wbs_d  = WB_sel2;
            rwe_d  = reg_w_en2;
            rd_d   = rdest1;
            rt_d   = rt_data1;
            brt_d  = Brch2 & cond;
            bpc_d  = PC4 + {{51{BImm2[11]}}, BImm2, 1'b0};
            if (multi) begin
                state_d = is_mul ? MUL : DIV;
                cnt_d   = 6'd0;
                hi_d    = 64'd0;
                lo_d    = is_mul ? b_mag : a_mag;
                m_d     = is_mul ? a_mag : b_mag;
                op_d    = ALU_ctrl2;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dz_d    = src_b == 64'd0;
            end else begin
                res_d   = alu;
                valid_d = 1'b1;
            end
        end
        case (state_q)
            MUL: begin
                hi_d    = msum[64:1];
                lo_d    = {msum[0], lo_q[63:1]};
                cnt_d   = cnt_q + 6'd1;
                state_d = &cnt_q ? DONE : MUL;
            end
            DIV: begin
                hi_d    = ddiff[64] ? dt[63:0] : ddiff[63:0];
                lo_d    = {lo_q[62:0], ~ddiff[64]};
                cnt_d   = cnt_q + 6'd1;
                state_d = &cnt_q ? DONE : DIV;
            end
            DONE: begin
                res_d   = mres;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 64'd0;
            lo_q    <= 64'd0;
            m_q     <= 64'd0;
            op_q    <= 5'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= 64'd0;
            pc_q    <= 64'd0;
            ins_q   <= 32'd0;
            memw_q  <= 1'b0;
            wbs_q   <= 1'b0;
            rwe_q   <= 1'b0;
            rd_q    <= 5'd0;
            rt_q    <= 64'd0;
            bpc_q   <= 64'd0;
            brt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            memw_q  <= memw_d;
            wbs_q   <= wbs_d;
            rwe_q   <= rwe_d;
            rd_q    <= rd_d;
            rt_q    <= rt_d;
            bpc_q   <= bpc_d;
            brt_q   <= brt_d;
        end
    end

    assign valid5     = valid_q;
    assign result     = res_q;
    assign rdest1_    = rd_q;
    assign reg_w_en3_ = rwe_q & valid_q;
    assign PC5        = pc_q;
    assign Ins4       = ins_q;
    assign MEM_W_en3  = memw_q;
    assign WB_sel3    = wbs_q;
    assign rt_data2   = rt_q;
    assign Brch_taken = brt_q & valid_q;
    assign BPC        = bpc_q;
endmodule

// File: tb/tb_ysyx_22041071_exu.sv
// tb_ysyx_22041071_exu: directed and randomized checks of the execute stage
// against an arithmetic reference model.
module tb_ysyx_22041071_exu;
    logic        clk = 1'b0, reset, valid4, ready4, Brch2, MEM_W_en2, WB_sel2, reg_w_en2;
    logic        valid5, ready5, reg_w_en3_, MEM_W_en3, WB_sel3, Brch_taken;
    logic [63:0] PC4, src_a, src_b, rt_data1, result, PC5, rt_data2, BPC;
    logic [31:0] Ins3, Ins4;
    logic [11:0] BImm2;
    logic [4:0]  ALU_ctrl2, rdest1, rdest1_;
    int          checks = 0, failures = 0;

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    ysyx_22041071_exu dut (
        .clk(clk), .reset(reset), .valid4(valid4), .ready4(ready4), .PC4(PC4), .Ins3(Ins3),
        .BImm2(BImm2), .Brch2(Brch2), .ALU_ctrl2(ALU_ctrl2), .src_a(src_a), .src_b(src_b),
        .MEM_W_en2(MEM_W_en2), .WB_sel2(WB_sel2), .reg_w_en2(reg_w_en2), .rdest1(rdest1),
        .rt_data1(rt_data1), .valid5(valid5), .ready5(ready5), .result(result),
        .rdest1_(rdest1_), .reg_w_en3_(reg_w_en3_), .PC5(PC5), .Ins4(Ins4),
        .MEM_W_en3(MEM_W_en3), .WB_sel3(WB_sel3), .rt_data2(rt_data2),
        .Brch_taken(Brch_taken), .BPC(BPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        logic signed [127:0] pa, pb, p;
        logic [31:0] w;
        sa = a;
        sb = b;
        pa = {{64{a[63]}}, a};
        pb = {{64{b[63]}}, b};
        p = pa * pb;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << b[5:0];
            6: return a >> b[5:0];
            7: return sa >>> b[5:0];
            8: return {63'd0, sa < sb};
            9: return {63'd0, a < b};
            10: return sx(a[31:0] + b[31:0]);
            11: return sx(a[31:0] - b[31:0]);
            12: return sx(a[31:0] << b[4:0]);
            13: return sx(a[31:0] >> b[4:0]);
            14: begin w = $signed(a[31:0]) >>> b[4:0]; return sx(w); end
            16: return p[63:0];
            17: return p[127:64];
            18: begin
                if (b == 0) return '1;
                if (a == MIN && b == '1) return MIN;
                return sa / sb;
            end
            19: begin if (b == 0) return '1; return a / b; end
            20: begin
                if (b == 0) return a;
                if (a == MIN && b == '1) return 0;
                return sa % sb;
            end
            21: begin if (b == 0) return a; return a % b; end
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic br, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [63:0] pc);
        logic [63:0] rt, bpc;
        logic [31:0] ins;
        logic [4:0]  rd;
        logic        mw, wb, rw, tk;
        int          n, lo, w, lat;
        rt = {$urandom, $urandom};
        ins = $urandom;
        ins[14:12] = f3;
        rd = 5'($urandom);
        {mw, wb, rw} = 3'($urandom);
        tk = br & ref_br(f3, a, b);
        bpc = pc + {{51{imm[11]}}, imm, 1'b0};
        lat = (op >= 16 && op <= 21) ? 65 : 0;
        @(negedge clk);
        ALU_ctrl2 = op; src_a = a; src_b = b; Brch2 = br; Ins3 = ins; BImm2 = imm; PC4 = pc;
        rt_data1 = rt; rdest1 = rd; MEM_W_en2 = mw; WB_sel2 = wb; reg_w_en2 = rw; valid4 = 1'b1;
        w = 0;
        while (!ready4 && w < 100) begin @(negedge clk); w++; end
        chk("accept", {63'd0, ready4}, 64'd1);
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom}; PC4 = {$urandom, $urandom};
        rt_data1 = {$urandom, $urandom}; Ins3 = $urandom; rdest1 = 5'($urandom);
        n = 0;
        lo = 0;
        while (!valid5 && n < 200) begin
            if (!ready4) lo++;
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("latency op%0d", op), 64'(n), 64'(lat));
        chk("ready4_low_cycles", 64'(lo), 64'(lat));
        chk("ready4_after", {63'd0, ready4}, 64'd1);
        chk($sformatf("result op%0d a=%h b=%h", op, a, b), result, ref_alu(op, a, b));
        chk("reg_w_en3_", {63'd0, reg_w_en3_}, {63'd0, rw});
        chk("rdest1_", {59'd0, rdest1_}, {59'd0, rd});
        chk("PC5", PC5, pc);
        chk("Ins4", {32'd0, Ins4}, {32'd0, ins});
        chk("rt_data2", rt_data2, rt);
        chk("mem_wb", {62'd0, MEM_W_en3, WB_sel3}, {62'd0, mw, wb});
        chk("Brch_taken", {63'd0, Brch_taken}, {63'd0, tk});
        chk("BPC", BPC, bpc);
        @(posedge clk);
        #1;
        chk("drained", {61'd0, valid5, Brch_taken, reg_w_en3_}, 64'd0);
    endtask

    initial begin
        int seen;
        logic [4:0] op;
        logic [63:0] a, b;
        reset = 1'b0; valid4 = 1'b0; ready5 = 1'b1; PC4 = 0; Ins3 = 0; BImm2 = 0; Brch2 = 0;
        ALU_ctrl2 = 0; src_a = 0; src_b = 0; MEM_W_en2 = 0; WB_sel2 = 0; reg_w_en2 = 0;
        rdest1 = 0; rt_data1 = 0;
        #1;
        chk("rst_valid5", {63'd0, valid5}, 64'd0);
        chk("rst_ready4", {63'd0, ready4}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_bpc_pc5", BPC | PC5 | rt_data2, 64'd0);
        chk("rst_flags", {58'd0, Brch_taken, reg_w_en3_, MEM_W_en3, WB_sel3, rdest1_ != 0, Ins4 != 0}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready4_after_reset", {63'd0, ready4}, 64'd1);

        issue(0, 64'd5, -64'd7, 0, 0, 0, 64'h1000);
        chk("add_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(16, 64'h1_0000_0000, 64'h1_0000_0000, 0, 0, 0, 64'h1004);
        issue(17, 64'h1_0000_0000, 64'h1_0000_0000, 0, 0, 0, 64'h1008);
        issue(18, -64'd7, 64'd2, 0, 0, 0, 64'h100c);
        issue(20, -64'd7, 64'd2, 0, 0, 0, 64'h1010);
        issue(19, 64'd7, 64'd0, 0, 0, 0, 64'h1014);
        issue(20, 64'd7, 64'd0, 0, 0, 0, 64'h1018);
        issue(18, MIN, '1, 0, 0, 0, 64'h101c);
        issue(20, MIN, '1, 0, 0, 0, 64'h1020);
        issue(18, -64'd9, 64'd0, 0, 0, 0, 64'h1024);
        issue(25, 64'd3, 64'd4, 0, 0, 0, 64'h1028);
        issue(0, 64'd1, 64'd2, 1, 3'b001, 12'h008, 64'h8000_0000);
        chk("bpc_const", BPC, 64'h8000_0010);
        issue(1, 64'd1, 64'd1, 1, 3'b000, 12'hFFE, 64'h8000_0100);

        @(negedge clk);
        ready5 = 1'b0; ALU_ctrl2 = 0; src_a = 64'd10; src_b = 64'd20; Brch2 = 0; reg_w_en2 = 1; valid4 = 1'b1;
        chk("bp_accept1", {63'd0, ready4}, 64'd1);
        @(posedge clk);
        #1;
        src_a = 64'd100; src_b = 64'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready4_low", {63'd0, ready4}, 64'd0);
            chk("bp_hold", {valid5, result[62:0]}, {1'b1, 63'd30});
        end
        ready5 = 1'b1;
        #1;
        chk("bp_ready4_release", {63'd0, ready4}, 64'd1);
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        chk("bp_second", {valid5, result[62:0]}, {1'b1, 63'd101});
        @(posedge clk);
        #1;
        chk("bp_no_dup", {63'd0, valid5}, 64'd0);

        @(negedge clk);
        ALU_ctrl2 = 18; src_a = 64'd1000; src_b = 64'd7; valid4 = 1'b1;
        @(posedge clk);
        #1;
        valid4 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_valid5", {63'd0, valid5}, 64'd0);
        chk("abort_ready4", {63'd0, ready4}, 64'd0);
        chk("abort_result", result, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready4_release", {63'd0, ready4}, 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (valid5) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        issue(0, 64'd40, 64'd2, 0, 0, 0, 64'h2000);

        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 21));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = 64'($signed($urandom_range(0, 40)) - 20);
            if ($urandom_range(0, 3) == 0) b = 64'($signed($urandom_range(0, 8)) - 4);
            issue(op, a, b, 1'($urandom), 3'($urandom), 12'($urandom), {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
